// File: rtl/conv_input_row_agu.sv
// Input-row address generator for the conv input buffer: walks tiles, input rows and
// features of a layer and streams one buffer word address per (row, feature) beat.
module conv_input_row_agu #(
    parameter int PIXELS_IN_ROW      = 32,
    parameter int PIXELS_IN_ROW_2POW = 5,
    parameter int BUFFERS_NUM        = 3,
    parameter int IFS_IN_ROW_2POW    = 1,
    parameter int BUF_DEPTH_2POW     = 12,
    parameter int DIM_W              = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_cfg_load,
    input  logic [3:0]                 i_cfg_k,
    input  logic [3:0]                 i_cfg_s,
    input  logic [3:0]                 i_cfg_p,
    input  logic [DIM_W-1:0]           i_cfg_ox,
    input  logic [DIM_W-1:0]           i_cfg_oy,
    input  logic [DIM_W-1:0]           i_cfg_iy,
    input  logic [DIM_W-1:0]           i_cfg_nif,
    input  logic [3:0]                 i_cfg_nif_2pow,
    input  logic [3:0]                 i_cfg_ix_2pow,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_adr_valid,
    input  logic                       i_adr_ready,
    output logic [DIM_W-1:0]           o_row_adr,
    output logic [IFS_IN_ROW_2POW-1:0] o_word_select,
    output logic                       o_pad,
    output logic [DIM_W-1:0]           o_if_idx,
    output logic [DIM_W-1:0]           o_iy_idx,
    output logic [DIM_W-1:0]           o_ox_start,
    output logic [DIM_W-1:0]           o_oy_start,
    output logic [DIM_W-1:0]           o_pox,
    output logic [DIM_W-1:0]           o_poy,
    output logic                       o_tile_last
);
    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
    localparam logic [DIM_W-1:0] PX  = DIM_W'(PIXELS_IN_ROW);
    localparam logic [DIM_W-1:0] BN  = DIM_W'(BUFFERS_NUM);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_next;

    logic [3:0]       r_cfg_k, r_cfg_s, r_cfg_p, r_cfg_nif2, r_cfg_ix2;
    logic [DIM_W-1:0] r_cfg_ox, r_cfg_oy, r_cfg_iy, r_cfg_nif;
    logic [DIM_W-1:0] r_oy, r_ox, r_r, r_if;

    logic [DIM_W-1:0] w_s, w_k, w_p, w_rem_x, w_rem_y, w_pox, w_poy, w_rows;
    logic [DIM_W-1:0] w_iy, w_ixm1, w_ifm1, w_mask, w_slot, w_adr;
    logic             w_pad, w_last_if, w_last_r, w_last_ox, w_last_oy;
    logic             w_run, w_acc, w_final;
    int               w_fsh, w_rsh, w_mexp;

    always_comb begin
        w_s       = {{(DIM_W-4){1'b0}}, r_cfg_s};
        w_k       = {{(DIM_W-4){1'b0}}, r_cfg_k};
        w_p       = {{(DIM_W-4){1'b0}}, r_cfg_p};
        w_rem_x   = r_cfg_ox - r_ox + ONE;
        w_rem_y   = r_cfg_oy - r_oy + ONE;
        w_last_ox = (w_rem_x <= PX);
        w_last_oy = (w_rem_y <= BN);
        w_pox     = w_last_ox ? w_rem_x : PX;
        w_poy     = w_last_oy ? w_rem_y : BN;
        w_rows    = (w_poy - ONE) * w_s + w_k;
        // iy_idx is two's complement: top rows of the first tile sit in the pad zone
        w_iy      = (r_oy - ONE) * w_s + r_r - w_p;
        w_pad     = w_iy[DIM_W-1] || (w_iy == '0) || (w_iy > r_cfg_iy);
        w_ixm1    = (r_ox - ONE) * w_s;
        w_ifm1    = r_if - ONE;
        w_fsh     = int'(r_cfg_nif2) - IFS_IN_ROW_2POW;
        if (w_fsh < 0) w_fsh = 0;
        w_rsh     = w_fsh + int'(r_cfg_ix2) - PIXELS_IN_ROW_2POW;
        if (w_rsh < 0) w_rsh = 0;
        w_mexp    = BUF_DEPTH_2POW - w_rsh;
        if (w_mexp < 0) w_mexp = 0;
        // a shift past DIM_W wraps the mask to all-ones, which is the intended no-wrap case
        w_mask    = (ONE << w_mexp) - ONE;
        w_slot    = (w_iy - ONE) & w_mask;
        w_adr     = (w_slot << w_rsh) + ((w_ixm1 >> PIXELS_IN_ROW_2POW) << w_fsh)
                    + (w_ifm1 >> IFS_IN_ROW_2POW);
        w_last_if = (r_if == r_cfg_nif);
        w_last_r  = (r_r == w_rows);
    end

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_adr_valid = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN: begin
                o_busy      = 1'b1;
                o_adr_valid = 1'b1;
                if (w_final) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_run   = (r_state == S_RUN);
    assign w_acc   = w_run & i_adr_ready;
    assign w_final = w_acc & w_last_if & w_last_r & w_last_ox & w_last_oy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_k    <= '0;
            r_cfg_s    <= '0;
            r_cfg_p    <= '0;
            r_cfg_nif2 <= '0;
            r_cfg_ix2  <= '0;
            r_cfg_ox   <= '0;
            r_cfg_oy   <= '0;
            r_cfg_iy   <= '0;
            r_cfg_nif  <= '0;
        end else if (r_state == S_IDLE && i_cfg_load) begin
            r_cfg_k    <= i_cfg_k;
            r_cfg_s    <= i_cfg_s;
            r_cfg_p    <= i_cfg_p;
            r_cfg_nif2 <= i_cfg_nif_2pow;
            r_cfg_ix2  <= i_cfg_ix_2pow;
            r_cfg_ox   <= i_cfg_ox;
            r_cfg_oy   <= i_cfg_oy;
            r_cfg_iy   <= i_cfg_iy;
            r_cfg_nif  <= i_cfg_nif;
        end
    end

    // loop nest, innermost first: feature, row, x-tile, y-tile
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_oy <= ONE;
            r_ox <= ONE;
            r_r  <= '0;
            r_if <= ONE;
        end else if (r_state == S_IDLE && i_start) begin
            r_oy <= ONE;
            r_ox <= ONE;
            r_r  <= ONE;
            r_if <= ONE;
        end else if (w_acc) begin
            if (!w_last_if) r_if <= r_if + ONE;
            else begin
                r_if <= ONE;
                if (!w_last_r) r_r <= r_r + ONE;
                else begin
                    r_r <= ONE;
                    if (!w_last_ox) r_ox <= r_ox + PX;
                    else begin
                        r_ox <= ONE;
                        if (!w_last_oy) r_oy <= r_oy + BN;
                        else begin
                            r_oy <= ONE;
                            r_r  <= '0;
                        end
                    end
                end
            end
        end
    end

    assign o_row_adr     = w_run ? (w_pad ? '1 : w_adr) : '0;
    assign o_word_select = w_ifm1[IFS_IN_ROW_2POW-1:0];
    assign o_pad         = w_run & w_pad;
    assign o_if_idx      = r_if;
    assign o_iy_idx      = w_run ? w_iy : '0;
    assign o_ox_start    = r_ox;
    assign o_oy_start    = r_oy;
    assign o_pox         = w_run ? w_pox : '0;
    assign o_poy         = w_run ? w_poy : '0;
    assign o_tile_last   = w_run & w_last_if & w_last_r;
endmodule

// File: tb/tb_conv_input_row_agu.sv
// Scoreboard bench for conv_input_row_agu: a loop-nest reference model queues expected
// beats, a negedge monitor pops and compares every accepted beat and the done pulse.
module tb_conv_input_row_agu;
    logic        clk = 0, rst_n = 0;
    logic        cfg_load = 0, start = 0, adr_ready = 0;
    logic [3:0]  cfg_k = 0, cfg_s = 0, cfg_p = 0, cfg_n2 = 0, cfg_x2 = 0;
    logic [15:0] cfg_ox = 0, cfg_oy = 0, cfg_iy = 0, cfg_nif = 0;
    logic        busy, done, adr_valid, pad, tile_last;
    logic [15:0] row_adr, if_idx, iy_idx, ox_start, oy_start, pox, poy;
    logic [0:0]  word_select;

    typedef struct packed {
        logic [15:0] adr; logic [0:0] ws; logic pad;
        logic [15:0] ifi, iy, oxs, oys, pox, poy; logic tl;
    } beat_t;

    beat_t q[$];
    int    errors = 0, checks = 0, n_acc = 0, n_done = 0;
    bit    hold_lo = 0, rand_ready = 0;
    bit    prev_stall = 0, exp_done = 0;
    beat_t prev_beat;

    conv_input_row_agu dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_load(cfg_load),
        .i_cfg_k(cfg_k), .i_cfg_s(cfg_s), .i_cfg_p(cfg_p),
        .i_cfg_ox(cfg_ox), .i_cfg_oy(cfg_oy), .i_cfg_iy(cfg_iy), .i_cfg_nif(cfg_nif),
        .i_cfg_nif_2pow(cfg_n2), .i_cfg_ix_2pow(cfg_x2), .i_start(start),
        .o_busy(busy), .o_done(done), .o_adr_valid(adr_valid), .i_adr_ready(adr_ready),
        .o_row_adr(row_adr), .o_word_select(word_select), .o_pad(pad),
        .o_if_idx(if_idx), .o_iy_idx(iy_idx), .o_ox_start(ox_start), .o_oy_start(oy_start),
        .o_pox(pox), .o_poy(poy), .o_tile_last(tile_last)
    );

    always #5 clk = ~clk;

    function automatic void chk(bit ok, string name, string got, string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s want %s", name, got, want);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        adr_ready = hold_lo ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    function automatic beat_t cur_beat();
        return {row_adr, word_select, pad, if_idx, iy_idx, ox_start, oy_start, pox, poy, tile_last};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            exp_done   = 0;
        end else begin
            beat_t b;
            b = cur_beat();
            if (prev_stall)
                chk(adr_valid && b == prev_beat, "hold_stable", $sformatf("%h", b), $sformatf("%h", prev_beat));
            if (exp_done) begin
                chk(done && !adr_valid && !busy, "done_timing",
                    $sformatf("d%0b v%0b b%0b", done, adr_valid, busy), "d1 v0 b0");
                n_done++;
            end else if (done) chk(0, "spurious_done", "done=1", "done=0");
            exp_done = 0;
            if (adr_valid && adr_ready) begin
                n_acc++;
                if (q.size() == 0) chk(0, "extra_beat", $sformatf("%h", b), "no beat");
                else begin
                    beat_t e;
                    e = q.pop_front();
                    chk(b == e, "beat", $sformatf("%h", b), $sformatf("%h", e));
                    if (q.size() == 0) exp_done = 1;
                end
            end
            prev_stall = adr_valid && !adr_ready;
            prev_beat  = b;
        end
    end

    // reference: plain loop nest over tiles, rows and features
    function automatic int model(int k, int s, int p, int ox, int oy, int iy, int nif, int n2, int x2);
        int cnt = 0;
        for (int oys = 1; oys <= oy; oys += 3) begin
            int py = (oy - oys + 1 < 3) ? oy - oys + 1 : 3;
            for (int oxs = 1; oxs <= ox; oxs += 32) begin
                int px = (ox - oxs + 1 < 32) ? ox - oxs + 1 : 32;
                int rr = (py - 1) * s + k;
                for (int r = 1; r <= rr; r++)
                    for (int f = 1; f <= nif; f++) begin
                        beat_t e;
                        int y    = (oys - 1) * s + r - p;
                        int ixs  = (oxs - 1) * s + 1;
                        int fsh  = n2 - 1;
                        int rsh  = fsh + x2 - 5;
                        int mask = (1 << (12 - rsh)) - 1;
                        e.pad = (y < 1) || (y > iy);
                        e.adr = e.pad ? 16'hFFFF
                              : 16'((((y - 1) & mask) << rsh) + (((ixs - 1) / 32) << fsh) + ((f - 1) / 2));
                        e.ws  = 1'((f - 1) % 2);
                        e.ifi = 16'(f);
                        e.iy  = 16'(y);
                        e.oxs = 16'(oxs);
                        e.oys = 16'(oys);
                        e.pox = 16'(px);
                        e.poy = 16'(py);
                        e.tl  = (r == rr) && (f == nif);
                        q.push_back(e);
                        cnt++;
                    end
            end
        end
        return cnt;
    endfunction

    task automatic load_cfg(int k, int s, int p, int ox, int oy, int iy, int nif, int n2, int x2);
        @(posedge clk); #2;
        cfg_k = 4'(k); cfg_s = 4'(s); cfg_p = 4'(p);
        cfg_ox = 16'(ox); cfg_oy = 16'(oy); cfg_iy = 16'(iy); cfg_nif = 16'(nif);
        cfg_n2 = 4'(n2); cfg_x2 = 4'(x2); cfg_load = 1;
        @(posedge clk); #2;
        cfg_load = 0;
    endtask

    // bp: 5-cycle ready stall mid-stream; poke: start/cfg_load with junk while busy
    task automatic run(int k, int s, int p, int ox, int oy, int iy, int nif, int n2, int x2,
                       int want_beats, bit bp, bit poke);
        int nb, acc0, done0, cyc;
        load_cfg(k, s, p, ox, oy, iy, nif, n2, x2);
        nb = model(k, s, p, ox, oy, iy, nif, n2, x2);
        if (want_beats > 0) chk(nb == want_beats, "model_beats", $sformatf("%0d", nb), $sformatf("%0d", want_beats));
        acc0 = n_acc; done0 = n_done;
        start = 1;
        @(posedge clk); #2;
        start = 0;
        @(negedge clk);
        chk(adr_valid && busy, "first_beat_latency", $sformatf("v%0b b%0b", adr_valid, busy), "v1 b1");
        if (poke) begin
            @(posedge clk); #2;
            start = 1; cfg_load = 1; cfg_k = 4'd9; cfg_oy = 16'd77; cfg_nif = 16'd5;
            @(posedge clk); #2;
            start = 0; cfg_load = 0;
        end
        if (bp) begin
            repeat (2) @(negedge clk);
            hold_lo = 1;
            repeat (5) @(negedge clk);
            hold_lo = 0;
        end
        cyc = 0;
        while (n_done == done0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk(cyc < 5000, "run_timeout", $sformatf("%0d cycles", cyc), "done pulse");
        @(negedge clk);
        chk(n_acc - acc0 == nb, "beat_count", $sformatf("%0d", n_acc - acc0), $sformatf("%0d", nb));
        q.delete();
    endtask

    task automatic check_reset_state();
        beat_t want;
        want = {16'd0, 1'b0, 1'b0, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 1'b0};
        chk(!busy && !done && !adr_valid, "reset_ctrl",
            $sformatf("b%0b d%0b v%0b", busy, done, adr_valid), "b0 d0 v0");
        chk(cur_beat() == want, "reset_outputs", $sformatf("%h", cur_beat()), $sformatf("%h", want));
    endtask

    initial begin
        int nb;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #2;
        rst_n = 1;

        run(3, 1, 1, 3, 3, 3, 2, 1, 5, 10, 0, 0);
        run(3, 2, 1, 4, 4, 8, 1, 1, 5, 10, 0, 0);
        run(1, 1, 0, 40, 1, 1, 1, 1, 6, 2, 0, 0);
        run(3, 1, 1, 3, 3, 3, 2, 1, 5, 10, 1, 0);
        run(3, 2, 1, 4, 4, 8, 1, 1, 5, 10, 0, 1);

        rand_ready = 1;
        for (int t = 0; t < 6; t++) begin
            int k  = $urandom_range(1, 4);
            int s  = $urandom_range(1, 3);
            int p  = $urandom_range(0, 2);
            int ox = $urandom_range(1, 70);
            int oy = $urandom_range(1, 7);
            int nf = $urandom_range(1, 4);
            run(k, s, p, ox, oy, $urandom_range(1, 20), nf, (nf > 2) ? 2 : 1,
                $urandom_range(5, 7), 0, t == 2, t == 4);
        end
        rand_ready = 0;

        // abort a run with reset, then restart from scratch
        load_cfg(3, 1, 1, 3, 3, 3, 2, 1, 5);
        nb = model(3, 1, 1, 3, 3, 3, 2, 1, 5);
        start = 1;
        @(posedge clk); #2;
        start = 0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        q.delete();
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #2;
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk(!busy && !done, "post_abort_idle", $sformatf("b%0b d%0b", busy, done), "b0 d0");
        run(3, 1, 1, 3, 3, 3, 2, 1, 5, nb, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
